// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rx, finds start bits, samples 8N1 frames at mid-bit
// and holds one byte for the register interface. Define UART_RX_PARITY_EN for 8E1/8O1 frames.
module uart_rx_framer #(
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] clock_divider,
  input  logic        rx,
  input  logic        read_en,
  output logic [7:0]  data_out,
  output logic        data_ready,
  output logic        framing_error,
  output logic        overrun,
  output logic        parity_error,
  output logic        busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for rx_s low
  // START  | half-bit wait, then confirm the start bit
  // DATA   | sampling 8 data bits, LSB first
  // PARITY | sampling the parity bit (parity build only)
  // STOP   | sampling the stop bit, commit or flag framing error
  // BREAK  | stop bit was low, wait for the line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_framer: illegal parameter value");
  end

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [15:0]            deff;
  logic [15:0]            cnt;
  logic                   expired;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign deff    = (clock_divider < 16'd2) ? 16'd2 : clock_divider;
  assign expired = (cnt == 16'd1);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic par_err_q;
  assign parity_error = par_err_q;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      sync_q        <= '1;
      cnt           <= 16'd0;
      bit_idx       <= 3'd0;
      shift_q       <= 8'd0;
      data_out      <= 8'd0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      par_err_q     <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};

      // Clears come first so that any flag raised by a frame in the same cycle wins.
      if (read_en) begin
        data_ready    <= 1'b0;
        framing_error <= 1'b0;
        overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_q     <= 1'b0;
`endif
      end

      if ((state inside {START, DATA, PARITY, STOP}) && !expired)
        cnt <= cnt - 16'd1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= deff >> 1;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (expired) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              cnt     <= deff;
              bit_idx <= 3'd0;
            end
          end
        end
        DATA: begin
          if (expired) begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt     <= deff;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (expired) begin
            par_bad_q <= (^{shift_q, rx_s}) != PARITY_ODD[0];
            cnt       <= deff;
            state     <= STOP;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        STOP: begin
          if (expired) begin
            if (rx_s) begin
              if (!data_ready || read_en) begin
                data_out   <= shift_q;
                data_ready <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (par_bad_q)
                par_err_q <= 1'b1;
`endif
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed scenarios plus randomized frames checked against
// a frame-level model of the held byte and sticky flags.
module tb_uart_rx_framer;

  localparam int SYNC = 2;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int PBITS = 1;
`else
  localparam int NBITS = 10;
  localparam int PBITS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clock_divider = 16'd16;
  logic        rx = 1'b0;
  logic        read_en = 1'b0;
  logic [7:0]  data_out;
  logic        data_ready, framing_error, overrun, parity_error, busy;

  always #5 clock = ~clock;

  uart_rx_framer #(.SYNC_STAGES(SYNC), .PARITY_ODD(PODD)) dut (
    .clock(clock), .reset(reset), .clock_divider(clock_divider), .rx(rx),
    .read_en(read_en), .data_out(data_out), .data_ready(data_ready),
    .framing_error(framing_error), .overrun(overrun), .parity_error(parity_error),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic prev_ready = 1'b0;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (data_ready === 1'b1 && prev_ready !== 1'b1) rise_cyc = cyc;
    prev_ready = data_ready;
  end

  // frame-level model of what software should see
  logic [7:0] m_data = 8'd0;
  logic m_ready = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/data_out"}, {8'd0, data_out}, {8'd0, m_data});
    check({tag, "/data_ready"}, {15'd0, data_ready}, {15'd0, m_ready});
    check({tag, "/framing_error"}, {15'd0, framing_error}, {15'd0, m_fe});
    check({tag, "/overrun"}, {15'd0, overrun}, {15'd0, m_ov});
    check({tag, "/parity_error"}, {15'd0, parity_error}, {15'd0, m_pe});
  endtask

  function automatic int deff_of(input int div);
    return (div < 2) ? 2 : div;
  endfunction

  function automatic int latency(input int d);
    return SYNC + d / 2 + (9 + PBITS) * d + 1;
  endfunction

  // caller is 1 time unit after a rising edge; returns likewise
  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stop_bit,
                            input int d);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, pbit, b, 1'b0};
`else
    bits = {pbit, stop_bit, b, 1'b0};
`endif
    start_cyc = cyc;
    for (int i = 0; i < NBITS; i++) begin
      rx = bits[i];
      repeat (d) @(posedge clock);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic read_pulse();
    read_en = 1'b1;
    @(posedge clock);
    #1;
    read_en = 1'b0;
    m_ready = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_pe = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic pbit, input logic stop_bit,
                             input logic read_at_commit);
    if (stop_bit) begin
      if (read_at_commit) begin
        m_fe = 1'b0;
        m_ov = 1'b0;
        m_pe = 1'b0;
      end
      if (!m_ready || read_at_commit) begin
        m_data = b;
        m_ready = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
      if (PBITS == 1 && (((^b) ^ pbit) != PODD[0])) m_pe = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return (^b) ^ PODD[0];
  endfunction

  initial begin
    logic [7:0] b;
    logic pbit, stop_bit, was_ready;
    int div, d;

    // reset with the line held low
    reset = 1'b1;
    rx = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all("reset");
    check("reset/busy", {15'd0, busy}, 16'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("post_reset/busy", {15'd0, busy}, 16'd0);
    end
    @(posedge clock);
    #1;

    // single frame, exact latency
    clock_divider = 16'd16;
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 16);
    model_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b0);
    idle(4);
    @(negedge clock);
    check("a5/latency", 16'(rise_cyc - start_cyc), 16'(latency(16)));
    check_all("a5");
    @(posedge clock);
    #1;
    read_pulse();
    @(negedge clock);
    check_all("a5_read");

    // back-to-back frames with no read -> overrun
    @(posedge clock);
    #1;
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 16);
    model_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b0);
    send_frame(8'h81, good_par(8'h81), 1'b1, 16);
    model_frame(8'h81, good_par(8'h81), 1'b1, 1'b0);
    idle(4);
    @(negedge clock);
    check_all("overrun");
    @(posedge clock);
    #1;
    read_pulse();
    @(negedge clock);
    check_all("overrun_read");

    // stop bit low -> framing error, busy held until line returns high
    @(posedge clock);
    #1;
    send_frame(8'h55, good_par(8'h55), 1'b0, 16);
    model_frame(8'h55, good_par(8'h55), 1'b0, 1'b0);
    @(negedge clock);
    check("break/busy_held", {15'd0, busy}, 16'd1);
    check_all("break");
    idle(4);
    @(negedge clock);
    check("break/busy_released", {15'd0, busy}, 16'd0);
    @(posedge clock);
    #1;
    read_pulse();

    // 4-cycle glitch -> false start
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    @(negedge clock);
    check("glitch/busy_rose", {15'd0, busy}, 16'd1);
    idle(20);
    @(negedge clock);
    check("glitch/busy_idle", {15'd0, busy}, 16'd0);
    check_all("glitch");

    // read_en in the exact commit cycle while another byte is held
    @(posedge clock);
    #1;
    send_frame(8'h11, good_par(8'h11), 1'b1, 16);
    model_frame(8'h11, good_par(8'h11), 1'b1, 1'b0);
    idle(4);
    fork
      send_frame(8'h7E, good_par(8'h7E), 1'b1, 16);
      begin
        repeat (latency(16) - 1) @(posedge clock);
        #1;
        read_en = 1'b1;
        @(posedge clock);
        #1;
        read_en = 1'b0;
      end
    join
    model_frame(8'h7E, good_par(8'h7E), 1'b1, 1'b1);
    idle(4);
    @(negedge clock);
    check_all("read_at_commit");

`ifdef UART_RX_PARITY_EN
    // even parity, 0x01 with parity bit 0 is a mismatch
    @(posedge clock);
    #1;
    read_pulse();
    send_frame(8'h01, 1'b0, 1'b1, 16);
    model_frame(8'h01, 1'b0, 1'b1, 1'b0);
    idle(4);
    @(negedge clock);
    check_all("parity_bad");
`endif

    // randomized frames against the model
    for (int n = 0; n < 16; n++) begin
      @(posedge clock);
      #1;
      b = 8'($urandom);
      div = (n == 0) ? 1 : $urandom_range(0, 24);
      d = deff_of(div);
      stop_bit = ($urandom_range(0, 5) != 0);
      pbit = good_par(b) ^ ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) read_pulse();
      clock_divider = 16'(div);
      was_ready = m_ready;
      send_frame(b, pbit, stop_bit, d);
      model_frame(b, pbit, stop_bit, 1'b0);
      idle(6);
      @(negedge clock);
      if (!was_ready && stop_bit)
        check("rand/latency", 16'(rise_cyc - start_cyc), 16'(latency(d)));
      check("rand/busy", {15'd0, busy}, 16'd0);
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
